// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared width default and engine state encoding for the GCD block
package gcd_pkg;

  localparam int GCD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtractive GCD engine (slave); busy only in CALC, valid only in DONE
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             y_en,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] y_data
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          a_d     = a;
          b_d     = b;
          state_d = CALC;
        end
      end
      CALC: begin
        // Zero operand terminates too, so gcd(0,x)=x and gcd(0,0)=0 without underflow
        if (a_q == b_q || a_q == '0 || b_q == '0) begin
          y_d     = (b_q == '0) ? a_q : b_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      DONE: begin
        if (req) begin
          a_d     = a;
          b_d     = b;
          state_d = CALC;
        end else if (y_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == CALC);
  assign valid  = (state_q == DONE);
  assign y_data = y_q;

endmodule

// File: rtl/gcd_master_slave.sv
// rtl/gcd_master_slave.sv - operand capture front end (master) driving the GCD engine
module gcd_master_slave
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             a_en,
  input  logic             b_en,
  input  logic             y_en,
  output logic             a_rdy,
  output logic             b_rdy,
  output logic             y_rdy,
  output logic [WIDTH-1:0] y_data
);

  logic [WIDTH-1:0] a_q, b_q;
  logic             a_vld, b_vld;
  logic             busy, valid, req;

  assign a_rdy = !busy;
  assign b_rdy = !busy;
  assign y_rdy = valid;

  // Held off while the engine computes so a completed operand pair is never dropped
  assign req = a_vld && b_vld && !busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      a_vld <= 1'b0;
      b_vld <= 1'b0;
    end else begin
      if (req) begin
        a_vld <= 1'b0;
        b_vld <= 1'b0;
      end
      if (a_en && a_rdy) begin
        a_q   <= a_data;
        a_vld <= 1'b1;
      end
      if (b_en && b_rdy) begin
        b_q   <= b_data;
        b_vld <= 1'b1;
      end
    end
  end

  gcd_engine #(.WIDTH(WIDTH)) u_engine (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req),
    .a      (a_q),
    .b      (b_q),
    .y_en   (y_en),
    .busy   (busy),
    .valid  (valid),
    .y_data (y_data)
  );

endmodule

// File: tb/tb_gcd_master_slave.sv
// tb/tb_gcd_master_slave.sv - directed self-checking bench for gcd_master_slave
module tb_gcd_master_slave;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] a_data, b_data;
  logic       a_en, b_en, y_en;
  logic       a_rdy, b_rdy, y_rdy;
  logic [3:0] y_data;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  gcd_master_slave #(.WIDTH(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_data (a_data),
    .b_data (b_data),
    .a_en   (a_en),
    .b_en   (b_en),
    .y_en   (y_en),
    .a_rdy  (a_rdy),
    .b_rdy  (b_rdy),
    .y_rdy  (y_rdy),
    .y_data (y_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic ea, input logic [3:0] va, input logic eb, input logic [3:0] vb);
    @(negedge clk_i);
    a_en = ea; a_data = va; b_en = eb; b_data = vb;
    @(negedge clk_i);
    a_en = 1'b0; b_en = 1'b0;
  endtask

  // Called in the cycle where req is high; counts cycles from the req edge to y_rdy
  task automatic wait_result(input string tag, input logic [3:0] exp_y, input int exp_lat, input bit poke);
    int cnt = 0;
    @(negedge clk_i);
    chk({tag, " a_rdy in calc"}, {31'd0, a_rdy}, 32'd0);
    chk({tag, " b_rdy in calc"}, {31'd0, b_rdy}, 32'd0);
    while (y_rdy !== 1'b1 && cnt < 40) begin
      if (poke) begin
        a_en   = ~cnt[0];
        a_data = 4'd3;
      end
      @(negedge clk_i);
      cnt++;
    end
    a_en = 1'b0;
    chk({tag, " latency"}, cnt, exp_lat);
    chk({tag, " y_data"}, {28'd0, y_data}, {28'd0, exp_y});
    chk({tag, " a_rdy in done"}, {31'd0, a_rdy}, 32'd1);
  endtask

  task automatic ack(input string tag, input logic [3:0] held_y);
    @(negedge clk_i);
    y_en = 1'b1;
    @(negedge clk_i);
    y_en = 1'b0;
    chk({tag, " y_rdy after ack"}, {31'd0, y_rdy}, 32'd0);
    chk({tag, " y_data after ack"}, {28'd0, y_data}, {28'd0, held_y});
  endtask

  initial begin
    rst_ni = 1'b0;
    a_en = 1'b0; b_en = 1'b0; y_en = 1'b0;
    a_data = '0; b_data = '0;
    #1;
    chk("reset a_rdy", {31'd0, a_rdy}, 32'd1);
    chk("reset b_rdy", {31'd0, b_rdy}, 32'd1);
    chk("reset y_rdy", {31'd0, y_rdy}, 32'd0);
    chk("reset y_data", {28'd0, y_data}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    offer(1'b1, 4'd12, 1'b1, 4'd8);
    wait_result("gcd12_8", 4'd4, 3, 1'b0);
    ack("gcd12_8", 4'd4);

    offer(1'b1, 4'd15, 1'b0, 4'd0);
    offer(1'b0, 4'd0, 1'b1, 4'd1);
    wait_result("gcd15_1", 4'd1, 15, 1'b1);
    ack("gcd15_1", 4'd1);

    offer(1'b1, 4'd0, 1'b1, 4'd9);
    wait_result("gcd0_9", 4'd9, 1, 1'b0);
    offer(1'b1, 4'd7, 1'b1, 4'd7);
    wait_result("gcd7_7", 4'd7, 1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hold y_rdy", {31'd0, y_rdy}, 32'd1);
      chk("hold y_data", {28'd0, y_data}, 32'd7);
    end
    ack("hold", 4'd7);

    offer(1'b1, 4'd5, 1'b0, 4'd0);
    offer(1'b1, 4'd10, 1'b0, 4'd0);
    offer(1'b0, 4'd0, 1'b1, 4'd4);
    wait_result("overwrite", 4'd2, 4, 1'b0);
    ack("overwrite", 4'd2);

    offer(1'b1, 4'd15, 1'b1, 4'd1);
    repeat (4) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort a_rdy", {31'd0, a_rdy}, 32'd1);
    chk("abort b_rdy", {31'd0, b_rdy}, 32'd1);
    chk("abort y_rdy", {31'd0, y_rdy}, 32'd0);
    chk("abort y_data", {28'd0, y_data}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("abort no result", {31'd0, y_rdy}, 32'd0);

    offer(1'b1, 4'd6, 1'b1, 4'd4);
    wait_result("gcd6_4", 4'd2, 3, 1'b0);
    ack("gcd6_4", 4'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
